// File: rtl/skew_filter_ctrl_pkg.sv
// Shared types and constants for the skewed two-bank tag filter controller.
// The optional statistics counters are enabled by defining SKEW_FILTER_CTRL_STATS_EN.
package skew_filter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PROBE,
        WRITE,
        RESP
    } state_t;

    typedef enum logic {
        KIND_LOOKUP,
        KIND_INSERT
    } kind_t;

    localparam int STAT_WIDTH = 32;
    localparam int NUM_STATS  = 3;

    // Saturating increment: an all-ones counter stays put instead of wrapping.
    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] value);
        return (value == '1) ? value : value + STAT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/skew_filter_ctrl_if.sv
// Request/response handshakes plus the shared bank probe/write bus of the filter controller.
// The slave modport is the controller; the master modport is the front-end and bank pair.
interface skew_filter_ctrl_if #(
    parameter int WIDTH = 64
);
    logic             lk_valid_i;
    logic             lk_ready_o;
    logic [WIDTH-1:0] lk_addr_i;
    logic             lk_resp_valid_o;
    logic             lk_hit_o;
    logic             ins_valid_i;
    logic             ins_ready_o;
    logic [WIDTH-1:0] ins_addr_i;
    logic             ins_done_o;
    logic             ins_dup_o;
    logic             bank_read_o;
    logic [WIDTH-1:0] bank_addr_o;
    logic [WIDTH-1:0] bank_wdata_o;
    logic             bank_write_l_o;
    logic             bank_write_r_o;
    logic             bank_hit_l_i;
    logic             bank_hit_r_i;

    modport slave (
        input  lk_valid_i, lk_addr_i, ins_valid_i, ins_addr_i, bank_hit_l_i, bank_hit_r_i,
        output lk_ready_o, lk_resp_valid_o, lk_hit_o, ins_ready_o, ins_done_o, ins_dup_o,
               bank_read_o, bank_addr_o, bank_wdata_o, bank_write_l_o, bank_write_r_o
    );

    modport master (
        output lk_valid_i, lk_addr_i, ins_valid_i, ins_addr_i, bank_hit_l_i, bank_hit_r_i,
        input  lk_ready_o, lk_resp_valid_o, lk_hit_o, ins_ready_o, ins_done_o, ins_dup_o,
               bank_read_o, bank_addr_o, bank_wdata_o, bank_write_l_o, bank_write_r_o
    );

endinterface

// File: rtl/skew_filter_ctrl_arb.sv
// Two-requester arbiter: a lone request always wins, and when both are pending the
// requester that lost last time is granted (prio_reg=1 favours inserts).
module skew_filter_ctrl_arb (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic lk_valid,
    input  logic ins_valid,
    output logic lk_ready,
    output logic ins_ready,
    output logic lk_grant,
    output logic ins_grant
);
    logic prio_reg;
    logic prio_next;

    always_comb begin
        lk_ready  = enable & ~(ins_valid & prio_reg);
        ins_ready = enable & ~(lk_valid & ~prio_reg);
        lk_grant  = lk_valid & lk_ready;
        ins_grant = ins_valid & ins_ready;
        prio_next = prio_reg;
        if (lk_grant) begin
            prio_next = 1'b1;
        end else if (ins_grant) begin
            prio_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_reg <= 1'b0;
        end else begin
            prio_reg <= prio_next;
        end
    end

endmodule

// File: rtl/skew_filter_ctrl.sv
// Sequencing controller for a two-bank skewed tag filter: probe-before-write inserts with
// alternating victim bank. Define SKEW_FILTER_CTRL_STATS_EN to add saturating stat counters.
module skew_filter_ctrl
    import skew_filter_ctrl_pkg::*;
#(
    parameter int WIDTH       = 64,
    parameter int TAG_WIDTH   = 12,
    parameter int INDEX_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    skew_filter_ctrl_if.slave     bus
`ifdef SKEW_FILTER_CTRL_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] stat_lookups_o,
    output logic [STAT_WIDTH-1:0] stat_hits_o,
    output logic [STAT_WIDTH-1:0] stat_inserts_o
`endif
);
    localparam bit WIDTHS_OK = (TAG_WIDTH + INDEX_WIDTH) <= WIDTH;

    state_t           state_reg, state_next;
    kind_t            kind_reg, kind_next;
    logic [WIDTH-1:0] addr_reg, addr_next;
    logic             hit_reg, hit_next;
    logic             dup_reg, dup_next;
    logic             victim_reg, victim_next;

    logic lk_ready, ins_ready, lk_grant, ins_grant;
    logic bank_read, write_l, write_r;
    logic lk_resp_valid, lk_hit, ins_done, ins_dup;

    skew_filter_ctrl_arb u_arb (
        .clk       (clk),
        .rst       (rst),
        .enable    (state_reg == IDLE),
        .lk_valid  (bus.lk_valid_i),
        .ins_valid (bus.ins_valid_i),
        .lk_ready  (lk_ready),
        .ins_ready (ins_ready),
        .lk_grant  (lk_grant),
        .ins_grant (ins_grant)
    );

    always_comb begin
        state_next    = state_reg;
        kind_next     = kind_reg;
        addr_next     = addr_reg;
        hit_next      = hit_reg;
        dup_next      = dup_reg;
        victim_next   = victim_reg;
        bank_read     = 1'b0;
        write_l       = 1'b0;
        write_r       = 1'b0;
        lk_resp_valid = 1'b0;
        lk_hit        = 1'b0;
        ins_done      = 1'b0;
        ins_dup       = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (lk_grant) begin
                    addr_next  = bus.lk_addr_i;
                    kind_next  = KIND_LOOKUP;
                    state_next = PROBE;
                end else if (ins_grant) begin
                    addr_next  = bus.ins_addr_i;
                    kind_next  = KIND_INSERT;
                    state_next = PROBE;
                end
            end
            PROBE: begin
                bank_read = 1'b1;
                hit_next  = bus.bank_hit_l_i | bus.bank_hit_r_i;
                if (kind_reg == KIND_LOOKUP) begin
                    state_next = RESP;
                end else if (bus.bank_hit_l_i | bus.bank_hit_r_i) begin
                    // Already present in either bank: never write a duplicate.
                    dup_next   = 1'b1;
                    state_next = RESP;
                end else begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                write_l     = ~victim_reg;
                write_r     = victim_reg;
                victim_next = ~victim_reg;
                dup_next    = 1'b0;
                state_next  = RESP;
            end
            RESP: begin
                if (kind_reg == KIND_LOOKUP) begin
                    lk_resp_valid = 1'b1;
                    lk_hit        = hit_reg;
                end else begin
                    ins_done = 1'b1;
                    ins_dup  = dup_reg;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            kind_reg   <= KIND_LOOKUP;
            addr_reg   <= '0;
            hit_reg    <= 1'b0;
            dup_reg    <= 1'b0;
            victim_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            kind_reg   <= kind_next;
            addr_reg   <= addr_next;
            hit_reg    <= hit_next;
            dup_reg    <= dup_next;
            victim_reg <= victim_next;
        end
    end

    assign bus.lk_ready_o      = lk_ready;
    assign bus.ins_ready_o     = ins_ready;
    assign bus.lk_resp_valid_o = lk_resp_valid;
    assign bus.lk_hit_o        = lk_hit;
    assign bus.ins_done_o      = ins_done;
    assign bus.ins_dup_o       = ins_dup;
    assign bus.bank_read_o     = bank_read;
    assign bus.bank_addr_o     = addr_reg;
    assign bus.bank_wdata_o    = addr_reg;
    assign bus.bank_write_l_o  = write_l;
    assign bus.bank_write_r_o  = write_r;

    a_one_strobe: assert property (@(posedge clk) disable iff (rst) !(write_l && write_r));
    a_widths_fit: assert property (@(posedge clk) WIDTHS_OK);

`ifdef SKEW_FILTER_CTRL_STATS_EN
    logic [NUM_STATS-1:0] stat_inc;

    // Index 0: lookups, 1: lookup hits, 2: inserts actually written.
    assign stat_inc[0] = (state_reg == RESP) && (kind_reg == KIND_LOOKUP);
    assign stat_inc[1] = (state_reg == RESP) && (kind_reg == KIND_LOOKUP) && hit_reg;
    assign stat_inc[2] = (state_reg == WRITE);

    for (genvar gi = 0; gi < NUM_STATS; gi++) begin : g_stat
        logic [STAT_WIDTH-1:0] count_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                count_reg <= '0;
            end else if (stat_inc[gi]) begin
                count_reg <= sat_inc(count_reg);
            end
        end
    end

    assign stat_lookups_o = g_stat[0].count_reg;
    assign stat_hits_o    = g_stat[1].count_reg;
    assign stat_inserts_o = g_stat[2].count_reg;
`endif

endmodule

// File: tb/tb_skew_filter_ctrl.sv
// Directed bench for skew_filter_ctrl with a behavioural two-bank model; every check is an
// immediate assertion against a hand-computed expectation.
module tb_skew_filter_ctrl;
    import skew_filter_ctrl_pkg::*;

    localparam int W = 64;

    logic clk = 1'b0;
    logic rst;
    int   total_checks = 0;
    int   passed_checks = 0;

    always #5 clk = ~clk;

    skew_filter_ctrl_if #(.WIDTH(W)) bus ();

`ifdef SKEW_FILTER_CTRL_STATS_EN
    logic [STAT_WIDTH-1:0] stat_lookups, stat_hits, stat_inserts;
`endif

    skew_filter_ctrl #(
        .WIDTH       (W),
        .TAG_WIDTH   (12),
        .INDEX_WIDTH (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef SKEW_FILTER_CTRL_STATS_EN
        ,
        .stat_lookups_o (stat_lookups),
        .stat_hits_o    (stat_hits),
        .stat_inserts_o (stat_inserts)
`endif
    );

    // Behavioural bank pair: each bank remembers written addresses, hit when probed.
    logic [W-1:0] mem_l [16];
    logic [W-1:0] mem_r [16];
    int           cnt_l = 0;
    int           cnt_r = 0;

    always @(posedge clk) begin
        if (rst) begin
            cnt_l <= 0;
            cnt_r <= 0;
        end else begin
            if (bus.bank_write_l_o && cnt_l < 16) begin
                mem_l[cnt_l] <= bus.bank_wdata_o;
                cnt_l <= cnt_l + 1;
            end
            if (bus.bank_write_r_o && cnt_r < 16) begin
                mem_r[cnt_r] <= bus.bank_wdata_o;
                cnt_r <= cnt_r + 1;
            end
        end
    end

    always_comb begin
        bus.bank_hit_l_i = 1'b0;
        bus.bank_hit_r_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (bus.bank_read_o && i < cnt_l && mem_l[i] == bus.bank_addr_o) bus.bank_hit_l_i = 1'b1;
            if (bus.bank_read_o && i < cnt_r && mem_r[i] == bus.bank_addr_o) bus.bank_hit_r_i = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total_checks++;
        assert (observed === expected) passed_checks++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_lookup(input logic [63:0] addr, input logic exp_hit);
        bus.lk_valid_i = 1'b1;
        bus.lk_addr_i  = addr;
        #1;
        check("lk_ready_grant", bus.lk_ready_o, 1);
        tick();
        bus.lk_valid_i = 1'b0;
        bus.lk_addr_i  = '0;
        check("lk_probe_read", bus.bank_read_o, 1);
        check("lk_probe_addr", bus.bank_addr_o, addr);
        check("lk_resp_early", bus.lk_resp_valid_o, 0);
        tick();
        check("lk_resp_valid", bus.lk_resp_valid_o, 1);
        check("lk_hit", bus.lk_hit_o, exp_hit);
        check("lk_ready_busy", bus.lk_ready_o, 0);
        tick();
        check("lk_resp_end", bus.lk_resp_valid_o, 0);
        check("lk_ready_again", bus.lk_ready_o, 1);
        $display("lookup addr=0x%0h hit=%0d", addr, exp_hit);
    endtask

    task automatic do_insert(input logic [63:0] addr, input logic exp_dup, input logic exp_right);
        bus.ins_valid_i = 1'b1;
        bus.ins_addr_i  = addr;
        #1;
        check("ins_ready_grant", bus.ins_ready_o, 1);
        tick();
        bus.ins_valid_i = 1'b0;
        bus.ins_addr_i  = '0;
        check("ins_probe_read", bus.bank_read_o, 1);
        check("ins_probe_addr", bus.bank_addr_o, addr);
        tick();
        if (!exp_dup) begin
            check("ins_write_l", bus.bank_write_l_o, !exp_right);
            check("ins_write_r", bus.bank_write_r_o, exp_right);
            check("ins_wdata", bus.bank_wdata_o, addr);
            check("ins_done_early", bus.ins_done_o, 0);
            tick();
        end
        check("ins_done", bus.ins_done_o, 1);
        check("ins_dup", bus.ins_dup_o, exp_dup);
        check("ins_no_strobe", {bus.bank_write_l_o, bus.bank_write_r_o}, 0);
        tick();
        check("ins_done_end", bus.ins_done_o, 0);
        check("ins_ready_again", bus.ins_ready_o, 1);
        $display("insert addr=0x%0h dup=%0d bank=%s", addr, exp_dup, exp_dup ? "none" : (exp_right ? "right" : "left"));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_lk;
        logic seen;
        rst             = 1'b1;
        bus.lk_valid_i  = 1'b0;
        bus.lk_addr_i   = '0;
        bus.ins_valid_i = 1'b0;
        bus.ins_addr_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_lk_ready", bus.lk_ready_o, 1);
        check("rst_ins_ready", bus.ins_ready_o, 1);
        check("rst_pulses", {bus.lk_resp_valid_o, bus.lk_hit_o, bus.ins_done_o, bus.ins_dup_o}, 0);
        check("rst_bank", {bus.bank_read_o, bus.bank_write_l_o, bus.bank_write_r_o}, 0);
`ifdef SKEW_FILTER_CTRL_STATS_EN
        check("rst_stats", {stat_lookups, stat_hits, stat_inserts}, 0);
`endif

        do_lookup(64'h4_0000, 1'b0);
        do_insert(64'h4_0000, 1'b0, 1'b0);
        do_lookup(64'h4_0000, 1'b1);
        do_insert(64'h4_0000, 1'b1, 1'b0);
        do_insert(64'h8_0000, 1'b0, 1'b1);
        do_insert(64'hC_0000, 1'b0, 1'b0);

        // Both requesters held valid: grants must alternate lookup, insert, lookup, insert.
        bus.lk_valid_i  = 1'b1;
        bus.lk_addr_i   = 64'h8_0000;
        bus.ins_valid_i = 1'b1;
        bus.ins_addr_i  = 64'h10_0000;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_lk = (k % 2 == 0);
            check("arb_lk_ready", bus.lk_ready_o, exp_lk);
            check("arb_ins_ready", bus.ins_ready_o, !exp_lk);
            seen = 1'b0;
            for (int c = 0; c < 8 && !seen; c++) begin
                tick();
                if (exp_lk ? bus.lk_resp_valid_o : bus.ins_done_o) seen = 1'b1;
            end
            check("arb_response", seen, 1);
            $display("arb grant %0d kind=%s", k, exp_lk ? "lookup" : "insert");
            tick();
        end
        bus.lk_valid_i  = 1'b0;
        bus.ins_valid_i = 1'b0;

        do_insert(64'h1C_0000, 1'b0, 1'b0);
`ifdef SKEW_FILTER_CTRL_STATS_EN
        check("stat_lookups", stat_lookups, 4);
        check("stat_hits", stat_hits, 3);
        check("stat_inserts", stat_inserts, 5);
`endif

        // Reset lands in the PROBE of an insert: the request must vanish without a trace.
        bus.ins_valid_i = 1'b1;
        bus.ins_addr_i  = 64'h14_0000;
        #1;
        check("rstp_ins_ready", bus.ins_ready_o, 1);
        tick();
        bus.ins_valid_i = 1'b0;
        check("rstp_probe", bus.bank_read_o, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rstp_no_strobe", {bus.bank_write_l_o, bus.bank_write_r_o}, 0);
        check("rstp_no_done", bus.ins_done_o, 0);
        check("rstp_lk_ready", bus.lk_ready_o, 1);
        check("rstp_ins_ready", bus.ins_ready_o, 1);
`ifdef SKEW_FILTER_CTRL_STATS_EN
        check("rstp_stats", {stat_lookups, stat_hits, stat_inserts}, 0);
`endif
        tick();
        check("rstp_quiet", {bus.ins_done_o, bus.bank_write_l_o, bus.bank_write_r_o}, 0);
        $display("reset during insert probe addr=0x14_0000 dropped");

        do_lookup(64'h4_0000, 1'b0);
        do_insert(64'h18_0000, 1'b0, 1'b0);
        do_lookup(64'h18_0000, 1'b1);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
